spi_slave_core: RTL and testbench
=================================

// Module: spi_slave_core
// PURPOSE
//  SPI slave (mode 0: CPOL=0, CPHA=0, MSB first): the responding end of FPGA_SPI_MASTER's link.
//  Oversamples SCLK/MOSI/SS in the CLK domain, shifts in one DATA_W-bit word per frame, and
//  shifts out TX_DATA on MISO. Sits at the FPGA pins and replaces the host-side echo logic.
// PARAMETERS
//  DATA_W       8   bits per word
//  SYNC_STAGES  2   flip-flop synchronizer depth on SCLK, MOSI and SS (>=2)
// PORTS
//  CLK        in   1       system clock; all logic on posedge
//  RST_N      in   1       asynchronous, active-low reset
//  SCLK       in   1       SPI clock from master (async to CLK)
//  MOSI       in   1       master-out data (async)
//  SS         in   1       slave select, active low (async)
//  MISO       out  1       slave-out data; 1'bz while deselected
//  TX_DATA    in   DATA_W  word to transmit; sampled at word start
//  TX_ACK     out  1       1-cycle pulse: TX_DATA captured into shifter
//  RX_DATA    out  DATA_W  last complete received word; held until next word
//  RX_VALID   out  1       1-cycle pulse: RX_DATA updated
//  BUSY       out  1       1 while state = ACTIVE
//  FRAME_ERR  out  1       1-cycle pulse: SS released mid-word
// BEHAVIOUR
//  Reset (RST_N=0, immediate): state IDLE, bit_cnt=0, shifters=0, RX_DATA=0, RX_VALID=0,
//   TX_ACK=0, FRAME_ERR=0, BUSY=0, MISO=z. Synchronizers reset to SCLK=0, MOSI=0, SS=1.
//  Sync: SCLK/MOSI/SS pass SYNC_STAGES FFs plus one edge-detect FF; MOSI delayed identically
//   to SCLK so sampling stays aligned. Constraint: SCLK high and low each >= SYNC_STAGES+2 CLKs.
//  FSM IDLE -> ACTIVE on synced SS fall: load tx_shift<=TX_DATA, pulse TX_ACK, bit_cnt<=0,
//   MISO drives tx_shift[DATA_W-1] same cycle (valid before master's first rising edge).
//  ACTIVE, synced SCLK rise: rx_shift<={rx_shift[DATA_W-2:0],MOSI_sync}; bit_cnt++.
//  ACTIVE, synced SCLK fall: tx_shift<<=1 and MISO presents next bit; if bit_cnt==0 (word just
//   ended) reload tx_shift<=TX_DATA instead and pulse TX_ACK (back-to-back words under SS low).
//  On the rise that makes bit_cnt==DATA_W: bit_cnt wraps to 0; next cycle RX_DATA<=word
//   (incl. that bit) and RX_VALID=1 for exactly one cycle.
//  ACTIVE -> IDLE on synced SS rise: MISO=z next cycle; if bit_cnt!=0 pulse FRAME_ERR and
//   discard partial word (RX_DATA unchanged, no RX_VALID).
//  Simultaneous: SS rise and SCLK edge in same cycle -> SS wins, edge ignored. SCLK edges in
//   IDLE ignored. SS fall and rise both pending cannot occur (edge-detected single signal).
//  TX_DATA must be stable from the TX_ACK cycle; later changes affect only the next word.
//  Reset mid-frame: all state cleared instantly; partial word lost; no pulses emitted.
//  RX_VALID and TX_ACK never assert in the same cycle as FRAME_ERR.
// TESTING
//  1. CLK 50MHz, SCLK 1MHz, TX_DATA=8'hA5, master sends 8'h3C -> MISO bits 1,0,1,0,0,1,0,1;
//     RX_DATA=8'h3C, one RX_VALID pulse, one TX_ACK pulse, FRAME_ERR never.
//  2. SS held low for 3 words 8'h01,8'h02,8'h03, TX_DATA updated after each TX_ACK to
//     8'h10,8'h20,8'h30 -> three RX_VALID with 01,02,03; MISO carries 10,20,30.
//  3. SS released after 5 SCLK rises -> FRAME_ERR pulse, RX_DATA keeps prior value, BUSY=0,
//     MISO=z within SYNC_STAGES+2 CLKs.
//  4. SCLK toggled 8x with SS high -> no RX_VALID/TX_ACK, MISO stays z, state IDLE.
//  5. RST_N pulsed low at bit 4 of a word -> outputs at reset values immediately; next full
//     frame after release received correctly.
//  6. SCLK at min legal half-period (SYNC_STAGES+2 CLKs), data 8'hFF then 8'h00 -> both words
//     received exactly.

Source files
------------

// File: rtl/spi_slave_core.sv
// spi_slave_core: mode-0 (CPOL=0, CPHA=0) MSB-first SPI slave, oversampled in the clk domain
//  clk        system clock, all logic on posedge
//  rst_n      asynchronous active-low reset
//  sclk       SPI clock from the master (asynchronous)
//  mosi       master-out data (asynchronous)
//  ss         slave select, active low (asynchronous)
//  miso       slave-out data, high-impedance while deselected
//  tx_data    word to transmit, captured at each word start
//  tx_ack     one-cycle pulse: tx_data captured into the shifter
//  rx_data    last complete received word, held until the next one
//  rx_valid   one-cycle pulse: rx_data updated
//  busy       high while a frame is active
//  frame_err  one-cycle pulse: ss released part-way through a word
module spi_slave_core #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ack,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic {IDLE, ACTIVE} state_t;
  // pins travel together as {ss, mosi, sclk} so mosi stays aligned with the sclk edge it belongs to
  logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
  logic [1:0]                  prev_q, prev_d;
  state_t                      state_q, state_d;
  logic [CW-1:0]               bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]           tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]           rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]           rx_data_q, rx_data_d;
  logic                        rx_valid_q, rx_valid_d;
  logic                        tx_ack_q, tx_ack_d;
  logic                        frame_err_q, frame_err_d;
  logic                        sclk_s, mosi_s, ss_s;
  logic                        sclk_rise, sclk_fall, ss_rise, ss_fall, last_bit;
  assign sclk_s    = sync_q[SYNC_STAGES-1][0];
  assign mosi_s    = sync_q[SYNC_STAGES-1][1];
  assign ss_s      = sync_q[SYNC_STAGES-1][2];
  assign sclk_rise = sclk_s & ~prev_q[0];
  assign sclk_fall = ~sclk_s & prev_q[0];
  assign ss_rise   = ss_s & ~prev_q[1];
  assign ss_fall   = ~ss_s & prev_q[1];
  assign last_bit  = bit_cnt_q == CW'(DATA_W - 1);
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], {ss, mosi, sclk}};
    prev_d = {ss_s, sclk_s};
  end
  // ss release outranks any sclk edge seen in the same cycle
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_ack_d    = 1'b0;
    frame_err_d = 1'b0;
    if (state_q == IDLE) begin
      if (ss_fall) begin
        state_d    = ACTIVE;
        tx_shift_d = tx_data;
        tx_ack_d   = 1'b1;
        bit_cnt_d  = '0;
      end
    end else if (ss_rise) begin
      state_d     = IDLE;
      frame_err_d = bit_cnt_q != '0;
      bit_cnt_d   = '0;
    end else if (sclk_rise) begin
      rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
      bit_cnt_d  = last_bit ? '0 : bit_cnt_q + CW'(1);
      rx_data_d  = last_bit ? {rx_shift_q[DATA_W-2:0], mosi_s} : rx_data_q;
      rx_valid_d = last_bit;
    end else if (sclk_fall) begin
      // a fall with bit_cnt at zero closes a word: start the next one straight away
      tx_shift_d = bit_cnt_q == '0 ? tx_data : tx_shift_q << 1;
      tx_ack_d   = bit_cnt_q == '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= {SYNC_STAGES{3'b100}};
      prev_q      <= 2'b10;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_ack_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_ack_q    <= tx_ack_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign busy      = state_q == ACTIVE;
  assign miso      = busy ? tx_shift_q[DATA_W-1] : 1'bz;
  assign tx_ack    = tx_ack_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: randomized mode-0 master driving spi_slave_core, checked against word-level expectations
module tb_spi_slave_core;
  localparam int W = 8;
  localparam int S = 2;
  localparam int MIN_H = S + 2;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sclk = 1'b0;
  logic         mosi = 1'b0;
  logic         ss = 1'b1;
  logic [W-1:0] tx_data = '0;
  wire          miso;
  logic         tx_ack, rx_valid, busy, frame_err;
  logic [W-1:0] rx_data;
  int tests = 0;
  int fails = 0;
  int n_ferr = 0;
  int n_overlap = 0;
  logic [W-1:0] rx_q[$], ack_q[$], tx_next_q[$], exp_tx[$], send_q[$], got_q[$];

  spi_slave_core #(.DATA_W(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .ss(ss), .miso(miso),
    .tx_data(tx_data), .tx_ack(tx_ack), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  // records every received word and every captured tx word; feeds the next tx word after each capture
  always @(negedge clk) if (rst_n) begin
    if (rx_valid) rx_q.push_back(rx_data);
    if (frame_err) n_ferr++;
    if (frame_err && (rx_valid || tx_ack)) n_overlap++;
    if (tx_ack) begin
      ack_q.push_back(tx_data);
      tx_data = tx_next_q.size() != 0 ? tx_next_q.pop_front() : W'($urandom);
    end
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic sbit(input logic b, input int h, input logic release_ss, output logic m);
    mosi = b;
    repeat (h) @(negedge clk);
    sclk = 1'b1;
    m = miso;
    repeat (h) @(negedge clk);
    sclk = 1'b0;
    if (release_ss) ss = 1'b1;
  endtask

  // sends send_q as one frame; ss rises together with the final sclk fall
  task automatic run_frame(input int h);
    logic [W-1:0] m;
    logic b;
    got_q.delete();
    ss = 1'b0;
    foreach (send_q[i]) begin
      for (int k = W - 1; k >= 0; k--) begin
        sbit(send_q[i][k], h, (i == send_q.size() - 1) && (k == 0), b);
        m[k] = b;
      end
      got_q.push_back(m);
    end
    repeat (h + S + 4) @(negedge clk);
  endtask

  task automatic load_tx();
    rx_q.delete();
    ack_q.delete();
    tx_next_q.delete();
    tx_data = exp_tx[0];
    for (int i = 1; i < exp_tx.size(); i++) tx_next_q.push_back(exp_tx[i]);
  endtask

  task automatic test_reset();
    #1;
    tests++; if (rx_data !== '0) begin fails++; $display("FAIL reset_rx_data got %h exp %h", rx_data, 8'h00); end
    tests++; if ({rx_valid, tx_ack, frame_err, busy} !== 4'b0000) begin fails++; $display("FAIL reset_pulses got %b exp 0000", {rx_valid, tx_ack, frame_err, busy}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    tests++; if (busy !== 1'b0 || ack_q.size() != 0) begin fails++; $display("FAIL reset_release_idle busy %b acks %0d exp 0 0", busy, ack_q.size()); end
  endtask

  task automatic test_single_word();
    int f0;
    f0 = n_ferr;
    exp_tx = '{8'hA5};
    send_q = '{8'h3C};
    load_tx();
    run_frame(25);
    tests++; if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin fails++; $display("FAIL single_rx count %0d exp 1, first %h exp 3c", rx_q.size(), rx_data); end
    tests++; if (got_q[0] !== 8'hA5) begin fails++; $display("FAIL single_miso got %h exp a5", got_q[0]); end
    tests++; if (ack_q.size() != 1) begin fails++; $display("FAIL single_tx_ack count %0d exp 1", ack_q.size()); end
    tests++; if (n_ferr != f0) begin fails++; $display("FAIL single_frame_err count %0d exp %0d", n_ferr, f0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_end got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    exp_tx = '{8'h10, 8'h20, 8'h30};
    send_q = '{8'h01, 8'h02, 8'h03};
    load_tx();
    run_frame(MIN_H + 3);
    tests++; if (rx_q.size() != 3) begin fails++; $display("FAIL b2b_rx_count got %0d exp 3", rx_q.size()); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (i >= rx_q.size() || rx_q[i] !== send_q[i]) begin fails++; $display("FAIL b2b_rx[%0d] got %h exp %h", i, i < rx_q.size() ? rx_q[i] : 8'hxx, send_q[i]); end
      tests++; if (got_q[i] !== exp_tx[i]) begin fails++; $display("FAIL b2b_miso[%0d] got %h exp %h", i, got_q[i], exp_tx[i]); end
    end
    tests++; if (ack_q.size() != 3) begin fails++; $display("FAIL b2b_tx_ack count %0d exp 3", ack_q.size()); end
  endtask

  task automatic test_frame_error();
    logic [W-1:0] prior;
    logic b;
    int f0;
    prior = rx_data;
    f0 = n_ferr;
    exp_tx = '{W'($urandom)};
    load_tx();
    ss = 1'b0;
    for (int k = 0; k < 5; k++) sbit(1'($urandom), MIN_H + 1, 1'b0, b);
    repeat (MIN_H) @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ferr_busy_mid got %b exp 1", busy); end
    ss = 1'b1;
    repeat (S + 2) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ferr_busy_after got %b exp 0", busy); end
    repeat (6) @(negedge clk);
    tests++; if (n_ferr != f0 + 1) begin fails++; $display("FAIL ferr_pulse count %0d exp %0d", n_ferr - f0, 1); end
    tests++; if (rx_data !== prior || rx_q.size() != 0) begin fails++; $display("FAIL ferr_rx_held got %h/%0d exp %h/0", rx_data, rx_q.size(), prior); end
  endtask

  task automatic test_idle_sclk();
    int f0;
    f0 = n_ferr;
    rx_q.delete();
    ack_q.delete();
    for (int k = 0; k < 8; k++) begin
      mosi = 1'($urandom);
      repeat (MIN_H) @(negedge clk);
      sclk = 1'b1;
      repeat (MIN_H) @(negedge clk);
      sclk = 1'b0;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy[%0d] got %b exp 0", k, busy); end
    end
    repeat (8) @(negedge clk);
    tests++; if (rx_q.size() != 0 || ack_q.size() != 0 || n_ferr != f0) begin fails++; $display("FAIL idle_pulses rx %0d ack %0d ferr %0d exp 0 0 0", rx_q.size(), ack_q.size(), n_ferr - f0); end
  endtask

  task automatic test_reset_mid_frame();
    logic b;
    int f0;
    exp_tx = '{8'hA5};
    load_tx();
    ss = 1'b0;
    for (int k = 0; k < 4; k++) sbit(1'($urandom), MIN_H + 2, 1'b0, b);
    repeat (2) @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_busy_before got %b exp 1", busy); end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    tests++; if (rx_data !== '0 || {rx_valid, tx_ack, frame_err, busy} !== 4'b0000) begin fails++; $display("FAIL rstmid_outputs rx %h flags %b exp 00 0000", rx_data, {rx_valid, tx_ack, frame_err, busy}); end
    ss = 1'b1;
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    f0 = n_ferr;
    repeat (8) @(negedge clk);
    exp_tx = '{W'($urandom)};
    send_q = '{W'($urandom)};
    load_tx();
    run_frame(MIN_H + 1);
    tests++; if (rx_q.size() != 1 || rx_q[0] !== send_q[0]) begin fails++; $display("FAIL rstmid_next_rx got %h (%0d words) exp %h", rx_data, rx_q.size(), send_q[0]); end
    tests++; if (got_q[0] !== exp_tx[0] || n_ferr != f0) begin fails++; $display("FAIL rstmid_next_miso got %h ferr %0d exp %h ferr 0", got_q[0], n_ferr - f0, exp_tx[0]); end
  endtask

  task automatic test_min_half_period();
    exp_tx = '{W'($urandom), W'($urandom)};
    send_q = '{8'hFF, 8'h00};
    load_tx();
    run_frame(MIN_H);
    tests++; if (rx_q.size() != 2 || rx_q[0] !== 8'hFF || rx_q[1] !== 8'h00) begin fails++; $display("FAIL minh_rx got %0d words last %h exp ff,00", rx_q.size(), rx_data); end
    tests++; if (got_q[0] !== exp_tx[0] || got_q[1] !== exp_tx[1]) begin fails++; $display("FAIL minh_miso got %h,%h exp %h,%h", got_q[0], got_q[1], exp_tx[0], exp_tx[1]); end
  endtask

  task automatic test_random();
    int n, h, f0;
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, 4);
      h = $urandom_range(MIN_H, MIN_H + 6);
      f0 = n_ferr;
      exp_tx.delete();
      send_q.delete();
      for (int i = 0; i < n; i++) begin
        exp_tx.push_back(W'($urandom));
        send_q.push_back(W'($urandom));
      end
      load_tx();
      run_frame(h);
      tests++; if (rx_q.size() != n || ack_q.size() != n || n_ferr != f0) begin fails++; $display("FAIL rand%0d_counts rx %0d ack %0d ferr %0d exp %0d %0d 0", f, rx_q.size(), ack_q.size(), n_ferr - f0, n, n); end
      for (int i = 0; i < n; i++) begin
        tests++; if (i >= rx_q.size() || rx_q[i] !== send_q[i] || got_q[i] !== exp_tx[i]) begin fails++; $display("FAIL rand%0d_word%0d rx %h miso %h exp %h %h", f, i, i < rx_q.size() ? rx_q[i] : 8'hxx, got_q[i], send_q[i], exp_tx[i]); end
      end
      tests++; if (rx_data !== send_q[n-1]) begin fails++; $display("FAIL rand%0d_rx_held got %h exp %h", f, rx_data, send_q[n-1]); end
    end
  endtask

  task automatic test_pulse_exclusive();
    tests++; if (n_overlap != 0) begin fails++; $display("FAIL pulse_exclusive overlaps %0d exp 0", n_overlap); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_frame_error();
    test_idle_sclk();
    test_min_half_period();
    test_reset_mid_frame();
    test_random();
    test_frame_error();
    test_pulse_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
